// File: rtl/jtag_debug_sys_mem_pkg.sv
// jtag_debug_sys_mem_pkg: shared types and sizes for the RAM command sequencer
package jtag_debug_sys_mem_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/jtag_debug_sys_mem_seq_skid.sv
// jtag_debug_sys_mem_seq_skid: 2-entry FIFO of {last, data} absorbing the RAM read latency
module jtag_debug_sys_mem_seq_skid
    import jtag_debug_sys_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              pop_last,
    output logic [DATA_W-1:0] pop_data,
    output logic [OCC_W-1:0]  occ,
    output logic              full,
    output logic              empty
);
    logic [DATA_W:0]  ent_q [SKID_DEPTH];
    logic             wp_q, wp_d, rp_q, rp_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            if (push) ent_q[wp_q] <= {push_last, push_data};
        end
    end

    assign {pop_last, pop_data} = ent_q[rp_q];
    assign occ   = occ_q;
    assign full  = occ_q == OCC_W'(SKID_DEPTH);
    assign empty = occ_q == '0;
endmodule

// File: rtl/jtag_debug_sys_mem_sequencer.sv
// jtag_debug_sys_mem_sequencer: block read/write sequencer driving a latency-1 Avalon-MM RAM
module jtag_debug_sys_mem_sequencer
    import jtag_debug_sys_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [BE_W-1:0]   cmd_byteenable,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              inflt_q, inflt_d, fin_q, fin_d, done_q, done_d;
    logic [OCC_W-1:0]  occ;
    logic              full, empty, pop, push, blocked, wr_beat, rd_issue, sk_last;
    logic [DATA_W-1:0] sk_data;

    // A read is issued only if its word is guaranteed a skid slot: occ + inflt - pop < 2.
    assign pop      = rsp_valid & rsp_ready;
    assign push     = ~reset & inflt_q;
    assign blocked  = ((full | ((occ == OCC_W'(1)) & inflt_q)) & ~pop) | (full & inflt_q);
    assign wr_beat  = ~reset & (state_q == WRITE) & wdata_valid;
    assign rd_issue = ~reset & (state_q == READ) & ~blocked;

    jtag_debug_sys_mem_seq_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_last (fin_q),
        .push_data (mem_readdata),
        .pop       (pop),
        .pop_last  (sk_last),
        .pop_data  (sk_data),
        .occ       (occ),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        fin_d   = fin_q;
        inflt_d = rd_issue;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                cnt_d   = cmd_len;
                be_d    = cmd_byteenable;
                state_d = cmd_write ? WRITE : READ;
            end
            WRITE: if (wdata_valid) begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (cnt_q == '0) ? IDLE : WRITE;
                done_d  = cnt_q == '0;
            end
            READ: if (rd_issue) begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                fin_d   = cnt_q == '0;
                state_d = (cnt_q == '0) ? DRAIN : READ;
            end
            DRAIN: if (inflt_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            fin_q   <= 1'b0;
            inflt_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            fin_q   <= fin_d;
            inflt_q <= inflt_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready      = ~reset & (state_q == IDLE);
    assign wdata_ready    = ~reset & (state_q == WRITE);
    assign busy           = ~reset & (state_q != IDLE);
    assign done           = ~reset & done_q;
    assign rsp_valid      = ~reset & ~empty;
    assign rsp_data       = rsp_valid ? sk_data : '0;
    assign rsp_last       = rsp_valid & sk_last;
    assign mem_chipselect = wr_beat | rd_issue;
    assign mem_write      = wr_beat;
    assign mem_address    = mem_chipselect ? addr_q : '0;
    assign mem_byteenable = wr_beat ? be_q : (rd_issue ? '1 : '0);
    assign mem_writedata  = wr_beat ? wdata : '0;
endmodule

// File: tb/tb_jtag_debug_sys_mem_sequencer.sv
// tb_jtag_debug_sys_mem_sequencer: directed checks of the RAM sequencer against a latency-1 RAM model
module tb_jtag_debug_sys_mem_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [9:0]  cmd_addr = '0, cmd_len = '0;
    logic [3:0]  cmd_byteenable = '0;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [31:0] wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_last;
    logic [31:0] rsp_data;
    logic        busy, done;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;

    logic [31:0] ram [1024];
    int          cyc, n_wr, n_rd, n_done, done_cyc, outst, max_outst, n_hold_err;
    int          wr_cyc[$], rsp_cyc[$];
    logic [32:0] rsp_log[$];
    logic        hold_pend;
    logic [32:0] hold_v;
    int          n_run, n_fail;

    jtag_debug_sys_mem_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end else if (mem_chipselect) begin
            mem_readdata <= ram[mem_address];
        end
    end

    always @(negedge clk) begin
        if (mem_chipselect && mem_write) begin
            n_wr <= n_wr + 1;
            wr_cyc.push_back(cyc);
        end
        if (mem_chipselect && !mem_write) n_rd <= n_rd + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (reset) begin
            outst     <= 0;
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && !(rsp_valid && {rsp_last, rsp_data} === hold_v)) n_hold_err <= n_hold_err + 1;
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back({rsp_last, rsp_data});
                rsp_cyc.push_back(cyc);
            end
            outst <= outst + int'(mem_chipselect && !mem_write) - int'(rsp_valid && rsp_ready);
            if (outst + int'(mem_chipselect && !mem_write) - int'(rsp_valid && rsp_ready) > max_outst)
                max_outst <= outst + int'(mem_chipselect && !mem_write) - int'(rsp_valid && rsp_ready);
            hold_pend <= rsp_valid && !rsp_ready;
            hold_v    <= {rsp_last, rsp_data};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [9:0] addr, input logic [9:0] len, input logic [3:0] be);
        int k;
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_byteenable = be; cmd_valid = 1'b1;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (k == 2000) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_block(input logic [9:0] addr, input logic [9:0] len, input logic [3:0] be, input logic [31:0] d0);
        int k;
        do_cmd(1'b1, addr, len, be);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = d0 + 32'(i); wdata_valid = 1'b1;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (wdata_ready) break;
            end
            @(posedge clk); #1;
            if (k == 100) begin
                check("wdata_ready_timeout", 0, 1);
                break;
            end
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_seen"}, 64'(k < lim), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int b, d0, r0, w0, e;
        logic [32:0] exp;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_strobe", mem_chipselect, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_quiet", {busy, done, rsp_valid, mem_chipselect, wdata_ready}, 0);
        @(posedge clk); #1;

        // 1: four-beat write at 0x005
        b = wr_cyc.size();
        wr_block(10'h005, 10'd3, 4'hF, 32'hA0);
        wait_done("t1", 20);
        check("t1_strobes", wr_cyc.size() - b, 4);
        check("t1_consec", wr_cyc[b+3] - wr_cyc[b], 3);
        check("t1_done_cyc", done_cyc, wr_cyc[b+3] + 1);
        for (int i = 0; i < 4; i++) check($sformatf("t1_ram%0d", 5 + i), ram[5+i], 32'hA0 + 32'(i));

        // 2: read back with rsp_ready held high
        rsp_ready = 1'b1;
        b = rsp_log.size(); r0 = n_rd; d0 = n_done;
        do_cmd(1'b0, 10'h005, 10'd3, 4'h0);
        wait_done("t2", 20);
        repeat (4) @(posedge clk); #1;
        check("t2_words", rsp_log.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            exp = {1'(i == 3), 32'hA0 + 32'(i)};
            check($sformatf("t2_word%0d", i), rsp_log[b+i], exp);
        end
        check("t2_consec", rsp_cyc[b+3] - rsp_cyc[b], 3);
        check("t2_rd_strobes", n_rd - r0, 4);
        check("t2_done_once", n_done - d0, 1);

        // 3: eight-word read with rsp_ready toggling every cycle
        wr_block(10'h010, 10'd7, 4'hF, 32'hB0);
        wait_done("t3w", 20);
        b = rsp_log.size(); d0 = n_done;
        do_cmd(1'b0, 10'h010, 10'd7, 4'h0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1 rsp_ready = ~rsp_ready;
            if (rsp_log.size() >= b + 8 && n_done > d0) break;
        end
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t3_words", rsp_log.size() - b, 8);
        e = 0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'(i == 7), 32'hB0 + 32'(i)};
            if (rsp_log[b+i] !== exp) e++;
        end
        check("t3_order", e, 0);
        check("t3_hold", n_hold_err, 0);
        check("t3_outstanding_le2", 64'(max_outst <= 2), 1);
        check("t3_done_once", n_done - d0, 1);

        // 4: wrapping write, full then low-half byteenable
        wr_block(10'h3FE, 10'd3, 4'hF, 32'hDEAD_0000);
        wait_done("t4a", 20);
        wr_block(10'h3FE, 10'd3, 4'b0011, 32'h5555_1230);
        wait_done("t4b", 20);
        check("t4_ram3fe", ram[10'h3FE], 32'hDEAD_1230);
        check("t4_ram3ff", ram[10'h3FF], 32'hDEAD_1231);
        check("t4_ram000", ram[10'h000], 32'hDEAD_1232);
        check("t4_ram001", ram[10'h001], 32'hDEAD_1233);

        // 5: full-RAM read from 0x200 after filling every word with 0x5A00_0000 | addr
        w0 = n_wr;
        wr_block(10'h000, 10'h3FF, 4'hF, 32'h5A00_0000);
        wait_done("t5w", 20);
        check("t5_fill_strobes", n_wr - w0, 1024);
        b = rsp_log.size(); r0 = n_rd; d0 = n_done;
        do_cmd(1'b0, 10'h200, 10'h3FF, 4'h0);
        wait_done("t5", 1200);
        repeat (4) @(posedge clk); #1;
        check("t5_words", rsp_log.size() - b, 1024);
        e = 0;
        for (int i = 0; i < 1024; i++) begin
            exp = {1'(i == 1023), 32'h5A00_0000 | ((32'h200 + 32'(i)) & 32'h3FF)};
            if (rsp_log[b+i] !== exp) e++;
        end
        check("t5_bad_words", e, 0);
        check("t5_rd_strobes", n_rd - r0, 1024);
        check("t5_done_once", n_done - d0, 1);

        // 6: reset during a ten-word read, then a clean follow-up read
        b = rsp_log.size();
        do_cmd(1'b0, 10'h000, 10'd9, 4'h0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_log.size() >= b + 2) break;
        end
        @(posedge clk); #1 reset = 1'b1;
        r0 = n_rd + n_wr; d0 = n_done;
        @(negedge clk);
        check("t6_rst_quiet", {mem_chipselect, rsp_valid, cmd_ready, busy, done}, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_strobes", (n_rd + n_wr) - r0, 0);
        check("t6_no_done", n_done - d0, 0);
        check("t6_idle", {rsp_valid, busy, cmd_ready}, 3'b001);
        @(posedge clk); #1;
        b = rsp_log.size(); d0 = n_done;
        do_cmd(1'b0, 10'h200, 10'd1, 4'h0);
        wait_done("t6", 20);
        repeat (3) @(posedge clk); #1;
        check("t6_words", rsp_log.size() - b, 2);
        check("t6_word0", rsp_log[b], {1'b0, 32'h5A00_0200});
        check("t6_word1", rsp_log[b+1], {1'b1, 32'h5A00_0201});
        check("t6_done_once", n_done - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
